// File: rtl/tl_ram_slave.sv
// Single-port TileLink-UL slave memory with 128-bit beats and multi-beat bursts.
// Optional address window check: define TL_RAM_BOUNDS_CHECK_EN to deny requests outside 0x8000_0000.
module tl_ram_slave #(
  parameter int AW = 14,
  parameter int DW = 128
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      tlslv_a_opcode,
  input  logic [2:0]      tlslv_a_param,
  input  logic [7:0]      tlslv_a_size,
  input  logic [2:0]      tlslv_a_source,
  input  logic [31:0]     tlslv_a_address,
  input  logic [DW/8-1:0] tlslv_a_mask,
  input  logic [DW-1:0]   tlslv_a_data,
  input  logic            tlslv_a_corrupt,
  input  logic            tlslv_a_valid,
  output logic            tlslv_a_ready,
  output logic [2:0]      tlslv_d_opcode,
  output logic [1:0]      tlslv_d_param,
  output logic [7:0]      tlslv_d_size,
  output logic [2:0]      tlslv_d_source,
  output logic [2:0]      tlslv_d_sink,
  output logic            tlslv_d_denied,
  output logic [DW-1:0]   tlslv_d_data,
  output logic            tlslv_d_corrupt,
  output logic            tlslv_d_valid,
  input  logic            tlslv_d_ready
);

  localparam int DP = 2**AW;
  localparam int MW = DW/8;

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD_RESP, S_ACK} state_e;

  logic [DW-1:0] ram [0:DP-1];

  state_e        state_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   cnt_q;
  logic [31:0]   bm1_q;
  logic          denied_q;

  logic          a_hs, d_hs;
  logic [AW-1:0] a_idx;
  logic          op_put, op_get, oob, req_denied;
  logic          we;
  logic [AW-1:0] waddr;
  logic          unused_bits;

  // Beats minus one; saturates for absurd sizes so the counter compare stays well defined.
  function automatic logic [31:0] beats_m1(input logic [7:0] size);
    if (size <= 8'd4)       return 32'd0;
    else if (size >= 8'd36) return '1;
    else                    return (32'd1 << (size - 8'd4)) - 32'd1;
  endfunction

  assign a_hs   = tlslv_a_valid & tlslv_a_ready;
  assign d_hs   = tlslv_d_valid & tlslv_d_ready;
  assign a_idx  = tlslv_a_address[AW+3:4];
  assign op_put = (tlslv_a_opcode == 3'd0) || (tlslv_a_opcode == 3'd1);
  assign op_get = (tlslv_a_opcode == 3'd4);

`ifdef TL_RAM_BOUNDS_CHECK_EN
  localparam logic [31:0] BASE_SH = 32'h8000_0000 >> (AW+4);
  assign oob = (tlslv_a_address[31:AW+4] != BASE_SH[31-AW-4:0]);
`else
  assign oob = 1'b0;
`endif

  assign req_denied = !(op_put || op_get) || oob;

  assign unused_bits = ^{tlslv_a_param, tlslv_a_corrupt, tlslv_a_address};

  assign tlslv_d_param   = 2'd0;
  assign tlslv_d_sink    = 3'd0;
  assign tlslv_d_corrupt = 1'b0;

  always_comb begin
    we    = 1'b0;
    waddr = a_idx;
    if (a_hs && !rst) begin
      if (state_q == S_IDLE && op_put && !oob) begin
        we = 1'b1;
      end else if (state_q == S_WR && !denied_q) begin
        we    = 1'b1;
        waddr = idx_q + cnt_q[AW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < MW; b++) begin
        if (tlslv_a_mask[b]) ram[waddr][b*8 +: 8] <= tlslv_a_data[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      idx_q          <= '0;
      cnt_q          <= '0;
      bm1_q          <= '0;
      denied_q       <= 1'b0;
      tlslv_a_ready  <= 1'b1;
      tlslv_d_valid  <= 1'b0;
      tlslv_d_opcode <= 3'd0;
      tlslv_d_size   <= 8'd0;
      tlslv_d_source <= 3'd0;
      tlslv_d_denied <= 1'b0;
      tlslv_d_data   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (a_hs) begin
            idx_q          <= a_idx;
            bm1_q          <= beats_m1(tlslv_a_size);
            denied_q       <= req_denied;
            tlslv_d_size   <= tlslv_a_size;
            tlslv_d_source <= tlslv_a_source;
            tlslv_d_denied <= req_denied;
            if (op_get) begin
              state_q        <= S_RD_RESP;
              cnt_q          <= '0;
              tlslv_a_ready  <= 1'b0;
              tlslv_d_valid  <= 1'b1;
              tlslv_d_opcode <= 3'd1;
              tlslv_d_data   <= oob ? '0 : ram[a_idx];
            end else if (op_put && beats_m1(tlslv_a_size) != 32'd0) begin
              state_q <= S_WR;
              cnt_q   <= 32'd1;
            end else begin
              state_q        <= S_ACK;
              tlslv_a_ready  <= 1'b0;
              tlslv_d_valid  <= 1'b1;
              tlslv_d_opcode <= 3'd0;
              tlslv_d_data   <= '0;
            end
          end
        end
        S_WR: begin
          if (a_hs) begin
            if (cnt_q == bm1_q) begin
              state_q        <= S_ACK;
              tlslv_a_ready  <= 1'b0;
              tlslv_d_valid  <= 1'b1;
              tlslv_d_opcode <= 3'd0;
              tlslv_d_data   <= '0;
            end else begin
              cnt_q <= cnt_q + 32'd1;
            end
          end
        end
        S_RD_RESP: begin
          if (d_hs) begin
            if (cnt_q == bm1_q) begin
              state_q        <= S_IDLE;
              tlslv_a_ready  <= 1'b1;
              tlslv_d_valid  <= 1'b0;
              tlslv_d_opcode <= 3'd0;
              tlslv_d_denied <= 1'b0;
              tlslv_d_data   <= '0;
            end else begin
              cnt_q        <= cnt_q + 32'd1;
              tlslv_d_data <= denied_q ? '0 : ram[idx_q + cnt_q[AW-1:0] + AW'(1)];
            end
          end
        end
        S_ACK: begin
          if (d_hs) begin
            state_q        <= S_IDLE;
            tlslv_a_ready  <= 1'b1;
            tlslv_d_valid  <= 1'b0;
            tlslv_d_opcode <= 3'd0;
            tlslv_d_denied <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tl_ram_slave.sv
// Bench for tl_ram_slave: directed cases plus random Put/Get traffic checked against a flat memory model.
module tb_tl_ram_slave;
  localparam int AW = 14;
  localparam int DP = 2**AW;

  logic         clk, rst;
  logic [2:0]   a_opcode, a_param, a_source;
  logic [7:0]   a_size;
  logic [31:0]  a_address;
  logic [15:0]  a_mask;
  logic [127:0] a_data;
  logic         a_corrupt, a_valid, a_ready;
  logic [2:0]   d_opcode, d_source, d_sink;
  logic [1:0]   d_param;
  logic [7:0]   d_size;
  logic         d_denied, d_corrupt, d_valid, d_ready;
  logic [127:0] d_data;

  tl_ram_slave #(.AW(AW), .DW(128)) dut (
    .clk(clk), .rst(rst),
    .tlslv_a_opcode(a_opcode), .tlslv_a_param(a_param), .tlslv_a_size(a_size),
    .tlslv_a_source(a_source), .tlslv_a_address(a_address), .tlslv_a_mask(a_mask),
    .tlslv_a_data(a_data), .tlslv_a_corrupt(a_corrupt), .tlslv_a_valid(a_valid),
    .tlslv_a_ready(a_ready),
    .tlslv_d_opcode(d_opcode), .tlslv_d_param(d_param), .tlslv_d_size(d_size),
    .tlslv_d_source(d_source), .tlslv_d_sink(d_sink), .tlslv_d_denied(d_denied),
    .tlslv_d_data(d_data), .tlslv_d_corrupt(d_corrupt), .tlslv_d_valid(d_valid),
    .tlslv_d_ready(d_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [127:0] mem [0:DP-1];
  logic [127:0] pd [0:3];
  logic [15:0]  pm [0:3];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int nbeats(input logic [7:0] size);
    if (size <= 8'd4) return 1;
    return 1 << (size - 8'd4);
  endfunction

  function automatic bit is_put(input logic [2:0] op);
    return (op == 3'd0) || (op == 3'd1);
  endfunction

  function automatic bit denied_of(input logic [2:0] op, input logic [31:0] addr);
    bit bad;
    bad = !(is_put(op) || op == 3'd4);
`ifdef TL_RAM_BOUNDS_CHECK_EN
    if ((addr >> (AW+4)) != (32'h8000_0000 >> (AW+4))) bad = 1'b1;
`endif
    return bad;
  endfunction

  function automatic int idx_of(input logic [31:0] addr);
    return int'((addr >> 4) % DP);
  endfunction

  // Present one A beat at a falling edge and return at the falling edge after it was accepted.
  task automatic a_beat(input logic [2:0] op, input logic [7:0] size, input logic [2:0] src,
                        input logic [31:0] addr, input logic [127:0] data, input logic [15:0] mask);
    int n;
    a_opcode = op; a_size = size; a_source = src; a_address = addr;
    a_data = data; a_mask = mask; a_valid = 1'b1;
    a_param = 3'($urandom); a_corrupt = 1'b0;
    n = 0;
    while (!a_ready && n < 20) begin @(negedge clk); n++; end
    chk("a_accept", a_ready, 1);
    @(negedge clk);
    a_valid = 1'b0;
  endtask

  task automatic do_put(input logic [2:0] op, input logic [7:0] size, input logic [2:0] src,
                        input logic [31:0] addr);
    int beats, idx, n;
    bit den;
    den   = denied_of(op, addr);
    beats = is_put(op) ? nbeats(size) : 1;
    idx   = idx_of(addr);
    for (int k = 0; k < beats; k++) begin
      a_beat(op, size, src, addr, pd[k], pm[k]);
      if (!den) begin
        for (int b = 0; b < 16; b++)
          if (pm[k][b]) mem[(idx + k) % DP][b*8 +: 8] = pd[k][b*8 +: 8];
      end
      if (k < beats - 1) chk("wr_no_d", d_valid, 0);
    end
    n = 0;
    while (!d_valid && n < 10) begin @(negedge clk); n++; end
    chk("ack_valid", d_valid, 1);
    chk("ack_opcode", d_opcode, 0);
    chk("ack_source", d_source, src);
    chk("ack_size", d_size, size);
    chk("ack_denied", d_denied, den);
    chk("ack_data", d_data, 0);
    chk("ack_a_ready", a_ready, 0);
    @(negedge clk);
    chk("ack_done", d_valid, 0);
    chk("ack_idle_ready", a_ready, 1);
    for (int k = 0; k < beats; k++)
      chk("mem_put", dut.ram[(idx + k) % DP], mem[(idx + k) % DP]);
  endtask

  task automatic do_get(input logic [7:0] size, input logic [2:0] src, input logic [31:0] addr,
                        input int stall_beat, input int stall_len);
    int beats, idx;
    bit den;
    logic [127:0] exp;
    den   = denied_of(3'd4, addr);
    beats = nbeats(size);
    idx   = idx_of(addr);
    d_ready = 1'b1;
    a_beat(3'd4, size, src, addr, '0, '0);
    for (int k = 0; k < beats; k++) begin
      exp = den ? '0 : mem[(idx + k) % DP];
      chk("get_valid", d_valid, 1);
      chk("get_opcode", d_opcode, 1);
      chk("get_source", d_source, src);
      chk("get_size", d_size, size);
      chk("get_denied", d_denied, den);
      chk("get_data", d_data, exp);
      chk("get_a_ready", a_ready, 0);
      if (k == stall_beat) begin
        d_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          @(negedge clk);
          chk("stall_valid", d_valid, 1);
          chk("stall_data", d_data, exp);
        end
        d_ready = 1'b1;
      end
      @(negedge clk);
    end
    chk("get_done", d_valid, 0);
    chk("get_idle_ready", a_ready, 1);
  endtask

  initial begin
    logic [127:0] v, old5;
    a_valid = 0; a_opcode = 0; a_param = 0; a_size = 0; a_source = 0;
    a_address = 0; a_mask = 0; a_data = 0; a_corrupt = 0; d_ready = 1'b1;
    for (int i = 0; i < DP; i++) begin
      v = {$urandom, $urandom, $urandom, $urandom};
      dut.ram[i] = v;
      mem[i] = v;
    end
    dut.ram[0] = 128'hAAAA_0000_1111_2222_3333_4444_5555_000A; mem[0] = dut.ram[0];
    dut.ram[1] = 128'hBBBB_0000_6666_7777_8888_9999_CCCC_000B; mem[1] = dut.ram[1];

    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    chk("rst_a_ready", a_ready, 1);
    chk("rst_d_valid", d_valid, 0);
    chk("rst_d_opcode", d_opcode, 0);
    chk("rst_d_denied", d_denied, 0);

    // Get burst of two beats with a three-cycle D stall on beat 0.
    do_get(8'd5, 3'd3, 32'h8000_0000, 0, 3);

    pd[0] = 128'h0123; pm[0] = 16'hFFFF;
    do_put(3'd0, 8'd4, 3'd2, 32'h8000_0010);
    chk("putfull_ram1", dut.ram[1], 128'h0123);

    old5 = mem[5];
    pd[0] = {$urandom, $urandom, $urandom, 24'h0, 8'hAA}; pm[0] = 16'h0001;
    do_put(3'd1, 8'd4, 3'd1, 32'h8000_0050);
    chk("putpartial_byte0", dut.ram[5], {old5[127:8], 8'hAA});

    pd[0] = {$urandom, $urandom, $urandom, $urandom}; pm[0] = 16'hFFFF;
    do_put(3'd6, 8'd4, 3'd5, 32'h8000_0070);

    // Burst that wraps from the last word back to word 0.
    for (int k = 0; k < 4; k++) begin pd[k] = {$urandom, $urandom, $urandom, $urandom}; pm[k] = 16'hFFFF; end
    do_put(3'd0, 8'd5, 3'd4, 32'h8000_0000 | ((DP - 1) << 4));
    do_get(8'd5, 3'd6, 32'h8000_0000 | ((DP - 1) << 4), -1, 0);

    // Reset in the middle of a four-beat Get.
    d_ready = 1'b1;
    a_beat(3'd4, 8'd6, 3'd7, 32'h8000_0020, '0, '0);
    chk("rstmid_beat0", d_data, mem[2]);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_d_valid", d_valid, 0);
    chk("rstmid_a_ready", a_ready, 1);
    rst = 1'b0;
    do_get(8'd6, 3'd1, 32'h8000_0020, 2, 2);

    for (int t = 0; t < 24; t++) begin
      int r, sz;
      logic [31:0] addr;
      r    = int'($urandom_range(0, 3));
      sz   = int'($urandom_range(0, 6));
      addr = 32'h8000_0000 | ($urandom_range(0, 63) << 4) | $urandom_range(0, 15);
      for (int k = 0; k < 4; k++) begin
        pd[k] = {$urandom, $urandom, $urandom, $urandom};
        pm[k] = (r == 0) ? 16'hFFFF : 16'($urandom);
      end
      if (r < 2) do_put(3'(r), 8'(sz), 3'($urandom), addr);
      else do_get(8'(sz), 3'($urandom), addr, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
